program_loader: RTL and testbench

- Upstream boot stage for the RISC-V processor.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory from word address 0.
- Holds the processor in reset until the stream's last byte is committed, then releases it so execution starts from a fully loaded program.

---
 rtl/loader_pkg.sv | 17 +
 rtl/word_assembler.sv | 34 +++
 rtl/program_loader.sv | 140 ++++++++++++++
 tb/tb_program_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the program loader
package loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;
    localparam int IDX_W      = 2;

    typedef enum logic [2:0] {
        S_LOAD,
        S_WRITE,
        S_DRAIN,
        S_DONE,
        S_CHECK,
        S_FAIL
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs accepted bytes little-endian into 32-bit words
module word_assembler
    import loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          byte_en,
    input  logic [BYTE_W-1:0]             byte_data,
    input  logic                          byte_last,
    output logic [WORD_BYTES*BYTE_W-1:0]  word,
    output logic                          word_ready
);

    logic [IDX_W-1:0] idx;

    // A word closes on its fourth byte or early on the stream's last byte.
    assign word_ready = byte_en && ((idx == IDX_W'(WORD_BYTES - 1)) || byte_last);

    // Lane fill; the first byte of a word clears the upper lanes so short words are zero-padded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            word <= '0;
        end else if (byte_en) begin
            if (idx == '0) begin
                word <= {{(WORD_BYTES-1)*BYTE_W{1'b0}}, byte_data};
            end else begin
                word[{idx, 3'b000} +: BYTE_W] <= byte_data;
            end
            idx <= word_ready ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader streaming bytes into instruction memory (option: PROGRAM_LOADER_CHECKSUM_EN)
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BYTE_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_BYTES*BYTE_W-1:0] mem_wdata,
    output logic                         cpu_rst,
    output logic                         done,
    output logic [ADDR_W:0]              word_count,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    output logic                         err_checksum,
`endif
    output logic                         err_overflow
);

    state_t                         state;
    state_t                         state_nxt;
    logic                           armed;
    logic                           last_word;
    logic                           accept;
    logic                           full;
    logic                           load_byte;
    logic                           word_ready;
    logic [WORD_BYTES*BYTE_W-1:0]   word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]              ck;
`endif

    assign accept    = in_valid && in_ready;
    assign full      = (word_count == (ADDR_W+1)'(MAX_WORDS));
    assign load_byte = accept && (state == S_LOAD) && !full;

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_en    (load_byte),
        .byte_data  (in_data),
        .byte_last  (in_last),
        .word       (word),
        .word_ready (word_ready)
    );

    // State register plus counters and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_LOAD;
            armed        <= 1'b0;
            last_word    <= 1'b0;
            word_count   <= '0;
            err_overflow <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ck           <= '0;
            err_checksum <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (load_byte && word_ready) begin
                last_word <= in_last;
            end
            if (state == S_WRITE) begin
                word_count <= word_count + (ADDR_W+1)'(1);
            end
            if (accept && (state == S_LOAD) && full) begin
                err_overflow <= 1'b1;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (load_byte) begin
                ck <= ck ^ in_data;
            end
            if (accept && (state == S_CHECK) && (in_data != ck)) begin
                err_checksum <= 1'b1;
            end
`endif
        end
    end

    // Next-state and output decode; in_ready stays low until the first clock after reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = word_count[ADDR_W-1:0];
        mem_wdata = word;
        cpu_rst   = 1'b1;
        done      = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = armed;
                if (accept) begin
                    if (full) begin
                        state_nxt = in_last ? S_DONE : S_DRAIN;
                    end else if (word_ready) begin
                        state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state_nxt = last_word ? S_CHECK : S_LOAD;
`else
                state_nxt = last_word ? S_DONE : S_LOAD;
`endif
            end
            S_DRAIN: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_nxt = S_DONE;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_nxt = (in_data == ck) ? S_DONE : S_FAIL;
                end
            end
`endif
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - table-driven self-checking bench for program_loader
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        sel;
    logic [7:0]  in_data;
    logic        in_last;

    always #5 clk = ~clk;

    logic        ready_a, we_a, cpu_rst_a, done_a, ovf_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  wc_a;
    logic        ready_b, we_b, cpu_rst_b, done_b, ovf_b;
    logic [7:0]  addr_b;
    logic [31:0] wdata_b;
    logic [8:0]  wc_b;
    logic        valid_a, valid_b;

    assign valid_a = in_valid & ~sel;
    assign valid_b = in_valid & sel;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic ck_a, ck_b;
`endif

    program_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut_a (
        .clk(clk), .rst(rst), .in_valid(valid_a), .in_ready(ready_a),
        .in_data(in_data), .in_last(in_last), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .cpu_rst(cpu_rst_a), .done(done_a), .word_count(wc_a),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        .err_checksum(ck_a),
`endif
        .err_overflow(ovf_a)
    );

    program_loader #(.ADDR_W(8), .MAX_WORDS(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(valid_b), .in_ready(ready_b),
        .in_data(in_data), .in_last(in_last), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .cpu_rst(cpu_rst_b), .done(done_b), .word_count(wc_b),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        .err_checksum(ck_b),
`endif
        .err_overflow(ovf_b)
    );

    logic        cur_ready, cur_we, cur_cpu_rst, cur_done, cur_ovf;
    logic [7:0]  cur_addr;
    logic [31:0] cur_wdata;
    logic [8:0]  cur_wc;
    assign cur_ready   = sel ? ready_b   : ready_a;
    assign cur_we      = sel ? we_b      : we_a;
    assign cur_cpu_rst = sel ? cpu_rst_b : cpu_rst_a;
    assign cur_done    = sel ? done_b    : done_a;
    assign cur_ovf     = sel ? ovf_b     : ovf_a;
    assign cur_addr    = sel ? addr_b    : addr_a;
    assign cur_wdata   = sel ? wdata_b   : wdata_a;
    assign cur_wc      = sel ? wc_b      : wc_a;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write capture and handshake-overlap monitor
    int          nw = 0;
    logic [7:0]  wr_a [8];
    logic [31:0] wr_d [8];
    int          cyc = 0;
    int          we_cyc = 0;
    int          done_cyc = -1;
    int          viol = 0;

    always @(negedge clk) begin
        cyc++;
        if (cur_we) begin
            if (nw < 8) begin
                wr_a[nw] = cur_addr;
                wr_d[nw] = cur_wdata;
            end
            nw++;
            we_cyc = cyc;
        end
        if (cur_we && cur_ready) viol++;
        if (cur_done && done_cyc < 0) done_cyc = cyc;
    end

    task automatic do_reset(input logic s);
        sel = s;
        rst = 1'b0;
        #1;
        nw = 0;
        done_cyc = -1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!cur_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cur_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: in_ready=0 expected 1");
            in_valid = 1'b0;
            in_last  = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            @(negedge clk);
        end
    endtask

    logic [7:0] pool [26];

    task automatic send_stream(input int first, input int n, input int gap, input logic with_ck);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            send_byte(pool[first+i], (i == n-1));
            x = x ^ pool[first+i];
            repeat (gap) @(negedge clk);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (with_ck) send_byte(x, 1'b0);
`else
        if (with_ck && x === 8'hxx) $display("unreachable");
`endif
    endtask

    typedef struct {
        int               first;
        int               n;
        int               gap;
        logic             s;
        int               nwr;
        logic [2:0][31:0] w;
        logic [8:0]       wc;
        logic             ovf;
    } case_t;

    case_t cases [6];

    initial begin
        pool = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00,
                 8'h73, 8'h00, 8'h10, 8'h00,
                 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F,
                 8'hAB,
                 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                 8'h01, 8'h02, 8'h04, 8'h08};
        cases[0] = '{0,  8,  0, 1'b0, 2, {32'h0, 32'h00B00593, 32'h00A00513}, 9'd2, 1'b0};
        cases[1] = '{12, 5,  0, 1'b0, 2, {32'h0, 32'h0000006F, 32'h00A00513}, 9'd2, 1'b0};
        cases[2] = '{0,  12, 1, 1'b0, 3, {32'h00100073, 32'h00B00593, 32'h00A00513}, 9'd3, 1'b0};
        cases[3] = '{0,  12, 0, 1'b1, 2, {32'h0, 32'h00B00593, 32'h00A00513}, 9'd2, 1'b1};
        cases[4] = '{17, 1,  1, 1'b0, 1, {32'h0, 32'h0, 32'h000000AB}, 9'd1, 1'b0};
        cases[5] = '{0,  9,  0, 1'b1, 2, {32'h0, 32'h00B00593, 32'h00A00513}, 9'd2, 1'b1};

        rst = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values, then in_ready rises only after the first clock
        check("rst_in_ready", 32'(cur_ready), 32'd0);
        check("rst_mem_we", 32'(cur_we), 32'd0);
        check("rst_mem_addr", 32'(cur_addr), 32'd0);
        check("rst_mem_wdata", cur_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cur_cpu_rst), 32'd1);
        check("rst_done", 32'(cur_done), 32'd0);
        check("rst_word_count", 32'(cur_wc), 32'd0);
        check("rst_err_overflow", 32'(cur_ovf), 32'd0);
        rst = 1'b1;
        #1;
        check("release_in_ready", 32'(cur_ready), 32'd0);
        @(negedge clk);
        check("first_clock_in_ready", 32'(cur_ready), 32'd1);

        // Write latency: cycle after the 4th byte carries the write, then ready returns
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("lat_mem_we", 32'(cur_we), 32'd1);
        check("lat_in_ready", 32'(cur_ready), 32'd0);
        check("lat_mem_addr", 32'(cur_addr), 32'd0);
        check("lat_mem_wdata", cur_wdata, 32'h44332211);
        @(negedge clk);
        check("lat_we_drop", 32'(cur_we), 32'd0);
        check("lat_ready_back", 32'(cur_ready), 32'd1);

        // Partial word held with no timeout, processor stays in reset
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        repeat (10) @(negedge clk);
        check("hold_writes", 32'(nw), 32'd1);
        check("hold_word_count", 32'(cur_wc), 32'd1);
        check("hold_cpu_rst", 32'(cur_cpu_rst), 32'd1);
        check("hold_done", 32'(cur_done), 32'd0);

        // Asynchronous reset mid-load, then reload overwrites address 0
        rst = 1'b0;
        #1;
        check("midrst_word_count", 32'(cur_wc), 32'd0);
        check("midrst_in_ready", 32'(cur_ready), 32'd0);
        do_reset(1'b0);
        send_stream(18, 4, 0, 1'b1);
        repeat (4) @(negedge clk);
        check("reload_writes", 32'(nw), 32'd1);
        check("reload_addr", 32'(wr_a[0]), 32'd0);
        check("reload_data", wr_d[0], 32'hEFBEADDE);
        check("reload_word_count", 32'(cur_wc), 32'd1);
        check("reload_done", 32'(cur_done), 32'd1);
        check("done_in_ready", 32'(cur_ready), 32'd0);

        // Table-driven stream cases
        for (int c = 0; c < 6; c++) begin
            do_reset(cases[c].s);
            send_stream(cases[c].first, cases[c].n, cases[c].gap, !cases[c].ovf);
            repeat (4) @(negedge clk);
            check($sformatf("c%0d_nwrites", c), 32'(nw), 32'(cases[c].nwr));
            for (int k = 0; k < cases[c].nwr; k++) begin
                check($sformatf("c%0d_addr%0d", c, k), 32'(wr_a[k]), 32'(k));
                check($sformatf("c%0d_data%0d", c, k), wr_d[k], cases[c].w[k]);
            end
            check($sformatf("c%0d_word_count", c), 32'(cur_wc), 32'(cases[c].wc));
            check($sformatf("c%0d_err_overflow", c), 32'(cur_ovf), 32'(cases[c].ovf));
            check($sformatf("c%0d_done", c), 32'(cur_done), 32'd1);
            check($sformatf("c%0d_cpu_rst", c), 32'(cur_cpu_rst), 32'd0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
            if (!cases[c].ovf)
                check($sformatf("c%0d_release_delay", c), 32'(done_cyc - we_cyc), 32'd1);
`endif
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        do_reset(1'b0);
        send_stream(22, 4, 0, 1'b0);
        send_byte(8'h0F, 1'b1);
        repeat (3) @(negedge clk);
        check("ck_good_done", 32'(cur_done), 32'd1);
        check("ck_good_err", 32'(ck_a), 32'd0);
        do_reset(1'b0);
        send_stream(22, 4, 0, 1'b0);
        send_byte(8'h0E, 1'b0);
        repeat (3) @(negedge clk);
        check("ck_bad_err", 32'(ck_a), 32'd1);
        check("ck_bad_cpu_rst", 32'(cur_cpu_rst), 32'd1);
        check("ck_bad_done", 32'(cur_done), 32'd0);
`endif

        check("we_while_ready", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
